// File: rtl/rpm_smoother.sv
// Moving-average RPM smoother: N-deep ring-buffer average of rate samples, scaled x60 with saturation.
// Latency 2 cycles from rate_valid to rpm_valid; accepts a sample every cycle, no backpressure.
module rpm_smoother #(
  parameter int W           = 24,
  parameter int LOG2N       = 3,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [W-1:0]     rate_in,
  input  logic             rate_valid,
  input  logic             clear,
  output logic [W-1:0]     rpm_out,
  output logic             rpm_valid,
  output logic [LOG2N:0]   fill_count,
  output logic             overflow
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = W + LOG2N;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_ring [N];
  logic [LOG2N-1:0] r_wr_ptr;
  logic [SW-1:0]    r_sum, w_sum_nxt;
  logic [IW-1:0]    r_idle;
  logic             r_v1;
  logic [W-1:0]     r_base;

  logic             w_accept, w_timeout, w_flush, w_fill_done;
  logic [W-1:0]     w_evict, w_base;
  logic [W+5:0]     w_scaled;

  // A sample in the same cycle as a timeout pre-empts it; clear drops the sample.
  assign w_accept    = rate_valid & ~clear;
  assign w_timeout   = ~rate_valid & ~clear & (r_idle == IW'(TIMEOUT_CYC - 1));
  assign w_flush     = clear | w_timeout;
  assign w_evict     = (r_state == RUN) ? r_ring[r_wr_ptr] : '0;
  assign w_sum_nxt   = r_sum + SW'(rate_in) - SW'(w_evict);
  assign w_fill_done = (r_state == RUN) | (fill_count == (LOG2N+1)'(N - 1));
  assign w_base      = w_fill_done ? w_sum_nxt[SW-1:LOG2N] : rate_in;

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush)
      w_state_nxt = FILL;
    else if (w_accept && (r_state == FILL) && (fill_count == (LOG2N+1)'(N - 1)))
      w_state_nxt = RUN;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      fill_count <= '0;
      r_idle     <= '0;
    end else if (w_flush) begin
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      fill_count <= '0;
      r_idle     <= '0;
    end else if (w_accept) begin
      r_sum    <= w_sum_nxt;
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_idle   <= '0;
      if (r_state == FILL) fill_count <= fill_count + 1'b1;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // Ring contents are only read in RUN, after every slot has been written.
  always_ff @(posedge mclk) begin
    if (w_accept) r_ring[r_wr_ptr] <= rate_in;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_base <= '0;
    end else begin
      r_v1 <= w_accept | w_timeout;
      if (w_accept)       r_base <= w_base;
      else if (w_timeout) r_base <= '0;
    end
  end

  assign w_scaled = {r_base, 6'b0} - {4'b0, r_base, 2'b0};

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rpm_valid <= 1'b0;
      rpm_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      rpm_valid <= r_v1;
      if (r_v1) begin
        if (|w_scaled[W+5:W]) begin
          rpm_out  <= '1;
          overflow <= 1'b1;
        end else begin
          rpm_out  <= w_scaled[W-1:0];
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rpm_smoother.sv
// Bench for rpm_smoother: directed scenarios then random samples/clears, checked against
// a sliding-window average model held as a queue of recent samples.
module tb_rpm_smoother;
  localparam int W = 24, LOG2N = 3, N = 8, TMO = 1000;

  logic          mclk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  rate_in;
  logic          rate_valid, clear;
  logic [W-1:0]  rpm_out;
  logic          rpm_valid, overflow;
  logic [LOG2N:0] fill_count;

  rpm_smoother #(.W(W), .LOG2N(LOG2N), .TIMEOUT_CYC(TMO)) dut (
    .mclk(mclk), .rst_n(rst_n), .rate_in(rate_in), .rate_valid(rate_valid),
    .clear(clear), .rpm_out(rpm_out), .rpm_valid(rpm_valid),
    .fill_count(fill_count), .overflow(overflow));

  always #5 mclk = ~mclk;

  typedef struct {
    longint val;
    bit     ovf;
    longint fill;
    bit     chk_fill;
    longint due;
    longint tol;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint win[$];
  longint cyc = 0;
  longint last_evt = 0;
  int     n_assert = 0;
  int     n_fail = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result of one accepted sample: pass-through until the window is full, then average.
  function automatic void model_sample(input longint r, input bit chk);
    longint s = 0;
    longint base, sc;
    exp_t e;
    win.push_back(r);
    if (win.size() > N) void'(win.pop_front());
    if (win.size() == N) begin
      foreach (win[i]) s += win[i];
      base = s / N;
    end else begin
      base = r;
    end
    sc         = 60 * base;
    e.ovf      = (sc >= (longint'(1) << W));
    e.val      = e.ovf ? (longint'(1) << W) - 1 : sc;
    e.fill     = win.size();
    e.chk_fill = chk;
    e.due      = cyc + 2;
    e.tol      = 0;
    sb.push_back(e);
  endfunction

  task automatic send(input logic [W-1:0] r, input bit vld, input bit clr, input int gap);
    rate_in    = r;
    rate_valid = vld;
    clear      = clr;
    if (clr) begin
      win.delete();
      last_evt = cyc + 1;
    end else if (vld) begin
      model_sample(longint'(r), gap >= 2);
      last_evt = cyc + 1;
    end
    @(posedge mclk); #1;
    rate_valid = 1'b0;
    clear      = 1'b0;
    repeat (gap) begin @(posedge mclk); #1; end
  endtask

  always @(negedge mclk) begin
    if (rst_n) begin
      if (rpm_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", longint'(rpm_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check("rpm_out", longint'(rpm_out), mon_e.val);
          check("overflow", longint'(overflow), longint'(mon_e.ovf));
          if (mon_e.tol == 0) check("latency", cyc, mon_e.due);
          else check("latency_window",
                     longint'((cyc + mon_e.tol >= mon_e.due) && (cyc <= mon_e.due + mon_e.tol)), 1);
          if (mon_e.chk_fill) check("fill_count", longint'(fill_count), mon_e.fill);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due + sb[0].tol) begin
        check("strobe_present", longint'(rpm_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t te;
    logic [W-1:0] r;
    rst_n = 1'b1; rate_in = '0; rate_valid = 1'b0; clear = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_rpm_out", longint'(rpm_out), 0);
    check("rst_rpm_valid", longint'(rpm_valid), 0);
    check("rst_overflow", longint'(overflow), 0);
    check("rst_fill_count", longint'(fill_count), 0);
    repeat (2) @(posedge mclk);
    #1 rst_n = 1'b1;
    @(posedge mclk); #1;

    // Fill with 10..80, then average.
    for (int i = 1; i <= 8; i++) send(W'(10 * i), 1'b1, 1'b0, 3);
    check("avg8_rpm", longint'(rpm_out), 2700);
    check("avg8_fill", longint'(fill_count), 8);

    // Eviction of the oldest sample and pointer wrap.
    send('0, 1'b1, 1'b0, 3);
    check("wrap_rpm", longint'(rpm_out), 2580);
    check("wrap_sum", longint'(dut.r_sum), 350);
    check("wrap_ptr", longint'(dut.r_wr_ptr), 1);

    // Saturation.
    for (int i = 0; i < N; i++) send(W'(300000), 1'b1, 1'b0, 3);
    check("sat_rpm", longint'(rpm_out), 16777215);
    check("sat_ovf", longint'(overflow), 1);

    // Idle timeout: one zero-valued strobe, window flushed.
    win.delete();
    te.val = 0; te.ovf = 1'b0; te.fill = 0; te.chk_fill = 1'b1;
    te.due = last_evt + TMO + 1; te.tol = 1;
    sb.push_back(te);
    for (int i = 0; i < TMO + 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge mclk);
    end
    #1;
    check("timeout_seen", longint'(sb.size()), 0);
    send(W'(5), 1'b1, 1'b0, 3);
    check("after_timeout_rpm", longint'(rpm_out), 300);

    // Clear colliding with a sample.
    send(W'(100), 1'b1, 1'b0, 3);
    send(W'(200), 1'b1, 1'b1, 3);
    check("clear_fill", longint'(fill_count), 0);

    // Back-to-back samples.
    for (int i = 0; i < 4; i++) send(W'(1000 + i), 1'b1, 1'b0, 0);
    repeat (3) begin @(posedge mclk); #1; end
    check("b2b_drained", longint'(sb.size()), 0);

    // Reset one cycle after a strobe discards the in-flight result.
    send(W'(777), 1'b1, 1'b0, 0);
    void'(sb.pop_back());
    win.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_rpm_out", longint'(rpm_out), 0);
    check("midrst_valid", longint'(rpm_valid), 0);
    check("midrst_fill", longint'(fill_count), 0);
    check("midrst_sum", longint'(dut.r_sum), 0);
    repeat (3) @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (5) begin @(posedge mclk); #1; end
    send(W'(7), 1'b1, 1'b0, 3);
    check("post_rst_rpm", longint'(rpm_out), 420);

    // Random samples, gaps and occasional clears.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) r = W'($urandom_range(0, (1 << W) - 1));
      else                           r = W'($urandom_range(0, 5000));
      send(r, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3));
    end
    repeat (6) begin @(posedge mclk); #1; end
    check("final_drained", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
